// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers.
// Define UART_ARB_TIMEOUT_EN to add a per-frame watchdog that aborts a frame with no done pulse.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16384
) (
    input  logic                       i_Clock,
    input  logic                       i_Reset,
    input  logic [NUM_REQ-1:0]         i_Req_Valid,
    input  logic [8*NUM_REQ-1:0]       i_Req_Byte,
    output logic [NUM_REQ-1:0]         o_Req_Ready,
    output logic                       o_Tx_DV,
    output logic [7:0]                 o_Tx_Byte,
    input  logic                       i_Tx_Active,
    input  logic                       i_Tx_Done,
    output logic [$clog2(NUM_REQ)-1:0] o_Grant_Id,
    output logic                       o_Busy,
    output logic                       o_Timeout
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);
    localparam logic [ID_W:0]   NumReqW = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LastId  = ID_W'(NUM_REQ - 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES nonzero");
    end

    typedef enum logic [1:0] {
        StIdle     = 2'b00,
        StWaitDone = 2'b01
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic              busy_q, busy_d;
    logic              dv_q, dv_d;
    logic [NUM_REQ-1:0] ready_q, ready_d;
    logic [7:0]        byte_q, byte_d;

`ifdef UART_ARB_TIMEOUT_EN
    logic [31:0]       cnt_q, cnt_d;
    logic              timeout_q, timeout_d;
`endif

    logic              found;
    logic [ID_W-1:0]   winner;
    logic [ID_W:0]     sum;
    logic [ID_W-1:0]   cand;
    logic [7:0]        win_byte;
    logic [ID_W-1:0]   ptr_inc;

    // Search pointer, pointer+1, ... with explicit wrap so non-power-of-2 counts work.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        sum      = '0;
        cand     = '0;
        win_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr_q} + (ID_W+1)'(i);
            if (sum >= NumReqW) begin
                sum = sum - NumReqW;
            end
            cand = sum[ID_W-1:0];
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found && i_Req_Valid[k] && (cand == ID_W'(k))) begin
                    found  = 1'b1;
                    winner = cand;
                end
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (winner == ID_W'(k)) begin
                win_byte = i_Req_Byte[8*k +: 8];
            end
        end
    end

    assign ptr_inc = (grant_q == LastId) ? '0 : grant_q + 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        byte_d  = byte_q;
        dv_d    = 1'b0;
        ready_d = '0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                // Waiting on i_Tx_Active lets a frame begun before reset finish cleanly.
                if (found && !i_Tx_Active) begin
                    byte_d  = win_byte;
                    dv_d    = 1'b1;
                    ready_d = NUM_REQ'(1) << winner;
                    grant_d = winner;
                    busy_d  = 1'b1;
                    state_d = StWaitDone;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            StWaitDone: begin
                if (i_Tx_Done) begin
                    busy_d  = 1'b0;
                    ptr_d   = ptr_inc;
                    state_d = StIdle;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_CYCLES - 1) begin
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                    ptr_d     = ptr_inc;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            dv_q      <= 1'b0;
            ready_q   <= '0;
            byte_q    <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            dv_q      <= dv_d;
            ready_q   <= ready_d;
            byte_q    <= byte_d;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign o_Req_Ready = ready_q;
    assign o_Tx_DV     = dv_q;
    assign o_Tx_Byte   = byte_q;
    assign o_Grant_Id  = grant_q;
    assign o_Busy      = busy_q;
`ifdef UART_ARB_TIMEOUT_EN
    assign o_Timeout   = timeout_q;
`else
    assign o_Timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural 40-clock transmitter and requester models.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int FRAME_CLKS = 40;
    localparam int TO_CYCLES  = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_byte;
    logic [3:0]  req_ready;
    logic        tx_dv;
    logic [7:0]  tx_byte_o;
    logic        tx_active;
    logic        tx_done;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TO_CYCLES)
    ) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Req_Valid (req_valid),
        .i_Req_Byte  (req_byte),
        .o_Req_Ready (req_ready),
        .o_Tx_DV     (tx_dv),
        .o_Tx_Byte   (tx_byte_o),
        .i_Tx_Active (tx_active),
        .i_Tx_Done   (tx_done),
        .o_Grant_Id  (grant_id),
        .o_Busy      (busy),
        .o_Timeout   (timeout)
    );

    typedef struct packed {
        logic [7:0] b;
        logic [1:0] id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cyc = -100;
    int   last_dv_cyc = 0;
    int   timeout_seen = 0;
    bit   gap_chk = 1'b0;
    int   req_cnt[4];

    // Transmitter model state
    logic tx_busy = 1'b0;
    logic tx_hold = 1'b0;
    logic tx_drop = 1'b0;
    logic tx_done_r = 1'b0;
    int   tx_left = 0;

    assign tx_active = tx_busy | tx_hold;
    assign tx_done   = tx_done_r;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [7:0] b, input logic [1:0] id);
        exp_t e;
        e.b  = b;
        e.id = id;
        sb.push_back(e);
    endtask

    task automatic request(input int k, input logic [7:0] b, input int n);
        req_byte[8*k +: 8] = b;
        req_cnt[k]         = n;
        req_valid[k]       = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!(sb.size() == 0 && !tx_busy && !tx_done_r && !busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s: idle not reached, %0d frames still expected", name, sb.size());
        end
        repeat (2) @(negedge clk);
    endtask

    // Requesters hold valid until they have seen req_cnt ready pulses.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < NUM_REQ; k++) begin
                if (req_ready[k] && req_cnt[k] > 0) begin
                    req_cnt[k]--;
                    if (req_cnt[k] == 0) req_valid[k] = 1'b0;
                end
            end
        end
    end

    // Transmitter: busy for FRAME_CLKS after a start pulse, then a one-cycle done.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_done_r) begin
                tx_done_r = 1'b0;
                if (!tx_dv) check("busy_after_done", busy, 0);
            end
            if (tx_dv) begin
                check("dv_while_tx_active", tx_active, 0);
                if (!tx_drop) begin
                    tx_busy = 1'b1;
                    tx_left = FRAME_CLKS;
                end
            end else if (tx_busy) begin
                tx_left--;
                if (tx_left == 0) begin
                    tx_busy   = 1'b0;
                    tx_done_r = 1'b1;
                    done_cyc  = cyc;
                end
            end
        end
    end

    // Monitor: every start pulse must match the next expected frame.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (tx_dv) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_dv: byte 0x%0h grant %0d, none expected",
                             tx_byte_o, grant_id);
                end else begin
                    e = sb.pop_front();
                    check("dv_byte", tx_byte_o, e.b);
                    check("dv_grant", grant_id, e.id);
                    check("dv_ready", req_ready, 32'd1 << e.id);
                    check("dv_busy", busy, 1);
                    if (gap_chk) check("dv_gap", cyc - done_cyc, 2);
                end
                last_dv_cyc = cyc;
            end else if (req_ready != 4'b0) begin
                check("ready_without_dv", req_ready, 0);
            end
            if (timeout) begin
                timeout_seen++;
`ifdef UART_ARB_TIMEOUT_EN
                check("timeout_delay", cyc - last_dv_cyc, TO_CYCLES);
`endif
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dv"}, tx_dv, 0);
        check({tag, "_ready"}, req_ready, 0);
        check({tag, "_byte"}, tx_byte_o, 0);
        check({tag, "_grant"}, grant_id, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_timeout"}, timeout, 0);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        req_valid = '0;
        req_byte  = '0;
        for (int k = 0; k < NUM_REQ; k++) req_cnt[k] = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Single byte from requester 2
        push(8'hA5, 2'd2);
        request(2, 8'hA5, 1);
        wait_idle("single_frame");

        // All four requesters from reset: 0,1,2,3,0 with 1-clock gaps
        rst = 1'b1;
        push(8'h11, 2'd0); push(8'h22, 2'd1); push(8'h33, 2'd2); push(8'h44, 2'd3);
        push(8'h11, 2'd0);
        request(0, 8'h11, 2); request(1, 8'h22, 1); request(2, 8'h33, 1); request(3, 8'h44, 1);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (sb.size() > 4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        gap_chk = 1'b1;
        wait_idle("round_robin");
        gap_chk = 1'b0;

        // Move pointer to 2, then 1 and 3 together: 3 wins, then 1
        push(8'h5A, 2'd1);
        request(1, 8'h5A, 1);
        wait_idle("ptr_setup");
        push(8'hB3, 2'd3); push(8'hB1, 2'd1);
        request(1, 8'hB1, 1); request(3, 8'hB3, 1);
        wait_idle("ptr2_pair");
        // Pointer should be back at 2: requester 2 beats requester 1
        push(8'hC2, 2'd2); push(8'hC1, 2'd1);
        request(1, 8'hC1, 1); request(2, 8'hC2, 1);
        wait_idle("ptr_end_2");

        // Reset mid-frame: nothing issues until the transmitter finishes
        push(8'h5C, 2'd3);
        request(3, 8'h5C, 1);
        n = 0;
        while (!tx_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        request(0, 8'h77, 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midframe_reset");
        rst = 1'b0;
        push(8'h77, 2'd0);
        wait_idle("after_midframe_reset");

        // Transmitter held busy: requests must wait
        tx_hold = 1'b1;
        request(2, 8'h3C, 1);
        repeat (20) @(negedge clk);
        check("hold_busy", busy, 0);
        push(8'h3C, 2'd2);
        tx_hold = 1'b0;
        wait_idle("active_hold");

        // Transmitter never answers
        tx_drop = 1'b1;
        push(8'h99, 2'd1);
`ifdef UART_ARB_TIMEOUT_EN
        push(8'hD2, 2'd2);
`endif
        request(1, 8'h99, 1);
        request(2, 8'hD2, 1);
        n = 0;
        while (sb.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("hung_frames_issued", sb.size(), 0);
`ifdef UART_ARB_TIMEOUT_EN
        check("timeout_seen", timeout_seen, 1);
`else
        repeat (150) @(negedge clk);
        check("hung_busy", busy, 1);
        check("hung_grant", grant_id, 1);
        check("timeout_never", timeout_seen, 0);
`endif
        rst       = 1'b1;
        req_valid = '0;
        for (int k = 0; k < NUM_REQ; k++) req_cnt[k] = 0;
        tx_drop   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
